// File: rtl/wishb_master_if.sv
// Request/response handshake plus Wishbone classic pins for wishb_master.
// Latency: none, this bundles wires only.
// Backpressure: req_ready/rsp_ready carry it; master = initiator view, slave = source/bus view.
interface wishb_master_if;
    // command port
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [25:0] req_adr;
    logic [31:0] req_dat;
    // response port
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    // Wishbone classic pins
    logic [25:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        we_o;
    logic        stb_o;
    logic        cyc_o;
    logic        ack_i;

    modport master (
        input  req_valid, req_we, req_adr, req_dat, rsp_ready, dat_i, ack_i,
        output req_ready, rsp_valid, rsp_dat, rsp_err, adr_o, dat_o, we_o, stb_o, cyc_o
    );

    modport slave (
        output req_valid, req_we, req_adr, req_dat, rsp_ready, dat_i, ack_i,
        input  req_ready, rsp_valid, rsp_dat, rsp_err, adr_o, dat_o, we_o, stb_o, cyc_o
    );
endinterface

// File: rtl/wishb_master.sv
// Wishbone classic single-cycle initiator fed by a valid/ready command port.
// Latency: cyc/stb from accept edge, response on the ack edge; 3 clocks per command minimum.
// Backpressure: one command in flight; req_ready low until the response is taken.
// Optional WISHB_MASTER_TIMEOUT_EN builds the ack timeout counter and the rsp_err path.
module wishb_master #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    wishb_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [25:0] adr_q;
    logic [31:0] dat_q;
    logic        we_q;
    logic        stb_q;
    logic        cyc_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_dat_q;
    logic        rsp_err_q;

`ifdef WISHB_MASTER_TIMEOUT_EN
    // Last count value before giving up: cyc drops TIMEOUT edges after accept.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt;
`else
    // Parameters only matter with the timeout built; keep them referenced.
    logic unused_cfg;
    assign unused_cfg = ^{8'(TIMEOUT), ERR_DATA};
`endif

    // Single FSM: accept a command, run one bus cycle, hold the response until taken.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            stb_q       <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
`ifdef WISHB_MASTER_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        adr_q <= bus.req_adr;
                        dat_q <= bus.req_dat;
                        we_q  <= bus.req_we;
                        cyc_q <= 1'b1;
                        stb_q <= 1'b1;
`ifdef WISHB_MASTER_TIMEOUT_EN
                        cnt   <= '0;
`endif
                        state <= BUS;
                    end
                end
                BUS: begin
                    // Ack is checked first so it wins over a simultaneous timeout.
                    if (bus.ack_i) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        we_q        <= 1'b0;
                        rsp_dat_q   <= we_q ? 32'h0 : bus.dat_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
`ifdef WISHB_MASTER_TIMEOUT_EN
                    else if (cnt == CNT_LAST) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_dat_q   <= we_q ? 32'h0 : ERR_DATA;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else if (cnt != 8'hFF) begin
                        // Saturate rather than wrap.
                        cnt <= cnt + 8'd1;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.adr_o     = adr_q;
    assign bus.dat_o     = dat_q;
    assign bus.we_o      = we_q;
    assign bus.stb_o     = stb_q;
    assign bus.cyc_o     = cyc_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wishb_master.sv
// Self-checking bench for wishb_master with a scoreboard of expected responses.
// A behavioural slave acks on the falling edge after ack_wait idle strobed clocks.
// Checks are sampled 1 time unit after each rising edge.
module tb_wishb_master;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];

    int          ack_wait    = 0;
    bit          slave_mute  = 1'b0;
    logic [31:0] slave_rdata = '0;
    int          slave_cnt   = 0;

    wishb_master_if bus();

    wishb_master #(
        .TIMEOUT  (16),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Slave: ack on a falling edge once the strobe has been up ack_wait clocks.
    initial begin
        bus.ack_i = 1'b0;
        bus.dat_i = '0;
        forever begin
            @(negedge clk);
            if (bus.stb_o && !bus.ack_i && !slave_mute) begin
                if (slave_cnt >= ack_wait) begin
                    bus.ack_i = 1'b1;
                    bus.dat_i = slave_rdata;
                    slave_cnt = 0;
                end else begin
                    slave_cnt++;
                end
            end else begin
                bus.ack_i = 1'b0;
                slave_cnt = 0;
            end
        end
    end

    // Present a command and hold it until accepted; returns just after the accept edge.
    task automatic send(input logic we, input logic [25:0] adr, input logic [31:0] dat,
                        output bit ok);
        bus.req_we    = we;
        bus.req_adr   = adr;
        bus.req_dat   = dat;
        bus.req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Count edges until cyc_o drops (or limit), noting any bus change while strobed.
    task automatic wait_drop(input int limit, output int k, output bit stable);
        logic [25:0] a;
        logic [31:0] d;
        logic        w;
        a = bus.adr_o;
        d = bus.dat_o;
        w = bus.we_o;
        k = 0;
        stable = 1'b1;
        while (k < limit) begin
            @(posedge clk);
            #1;
            k++;
            if (!bus.cyc_o) break;
            if (bus.adr_o !== a || bus.dat_o !== d || bus.we_o !== w || bus.stb_o !== 1'b1)
                stable = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (bus.cyc_o !== 1'b0 || bus.stb_o !== 1'b0 || bus.we_o !== 1'b0)
            begin n_fail++; $display("FAIL reset_ctl: cyc=%b stb=%b we=%b, want 0 0 0", bus.cyc_o, bus.stb_o, bus.we_o); end
        n_tests++;
        if (bus.adr_o !== 26'h0 || bus.dat_o !== 32'h0)
            begin n_fail++; $display("FAIL reset_bus: adr=%h dat=%h, want 0 0", bus.adr_o, bus.dat_o); end
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_dat !== 32'h0 || bus.rsp_err !== 1'b0)
            begin n_fail++; $display("FAIL reset_rsp: valid=%b dat=%h err=%b, want 0 0 0", bus.rsp_valid, bus.rsp_dat, bus.rsp_err); end
        n_tests++;
        if (bus.req_ready !== 1'b1)
            begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.cyc_o !== 1'b0)
            begin n_fail++; $display("FAIL reset_release: ready=%b cyc=%b, want 1 0", bus.req_ready, bus.cyc_o); end
        @(negedge clk);
    endtask

    task automatic test_write();
        bit ok, stable;
        int k;
        rsp_t e;
        ack_wait = 2;
        exp_q.push_back(rsp_t'{32'h0, 1'b0});
        send(1'b1, 26'h0010004, 32'h12345678, ok);
        n_tests++;
        if (!ok || bus.cyc_o !== 1'b1 || bus.stb_o !== 1'b1 || bus.adr_o !== 26'h0010004 ||
            bus.dat_o !== 32'h12345678 || bus.we_o !== 1'b1)
            begin n_fail++; $display("FAIL write_start: ok=%b cyc=%b stb=%b adr=%h dat=%h we=%b, want 1 1 1 0010004 12345678 1",
                ok, bus.cyc_o, bus.stb_o, bus.adr_o, bus.dat_o, bus.we_o); end
        wait_drop(20, k, stable);
        n_tests++;
        if (stable !== 1'b1)
            begin n_fail++; $display("FAIL write_stable: bus changed while stb high"); end
        n_tests++;
        if (k !== 3)
            begin n_fail++; $display("FAIL write_ack_edge: cyc dropped after %0d edges, want 3", k); end
        n_tests++;
        if (bus.stb_o !== 1'b0 || bus.we_o !== 1'b0 || bus.rsp_valid !== 1'b1)
            begin n_fail++; $display("FAIL write_end: stb=%b we=%b rsp_valid=%b, want 0 0 1", bus.stb_o, bus.we_o, bus.rsp_valid); end
        e = exp_q.pop_front();
        n_tests++;
        if (bus.rsp_dat !== e.dat || bus.rsp_err !== e.err)
            begin n_fail++; $display("FAIL write_rsp: dat=%h err=%b, want %h %b", bus.rsp_dat, bus.rsp_err, e.dat, e.err); end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
            begin n_fail++; $display("FAIL write_handshake: rsp_valid=%b ready=%b, want 0 1", bus.rsp_valid, bus.req_ready); end
        @(negedge clk);
    endtask

    task automatic test_read();
        bit ok, stable;
        int k;
        rsp_t e;
        ack_wait    = 1;
        slave_rdata = 32'hCAFEF00D;
        exp_q.push_back(rsp_t'{32'hCAFEF00D, 1'b0});
        send(1'b0, 26'h0000010, 32'h55555555, ok);
        n_tests++;
        if (!ok || bus.cyc_o !== 1'b1 || bus.adr_o !== 26'h0000010 || bus.we_o !== 1'b0)
            begin n_fail++; $display("FAIL read_start: ok=%b cyc=%b adr=%h we=%b, want 1 1 0000010 0", ok, bus.cyc_o, bus.adr_o, bus.we_o); end
        wait_drop(20, k, stable);
        n_tests++;
        if (stable !== 1'b1 || bus.we_o !== 1'b0)
            begin n_fail++; $display("FAIL read_we: stable=%b we=%b, want 1 0", stable, bus.we_o); end
        n_tests++;
        if (k !== 2)
            begin n_fail++; $display("FAIL read_ack_edge: cyc dropped after %0d edges, want 2", k); end
        e = exp_q.pop_front();
        n_tests++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== e.dat || bus.rsp_err !== e.err)
            begin n_fail++; $display("FAIL read_rsp: valid=%b dat=%h err=%b, want 1 %h %b", bus.rsp_valid, bus.rsp_dat, bus.rsp_err, e.dat, e.err); end
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok, stable;
        int k;
        slave_mute = 1'b1;
`ifdef WISHB_MASTER_TIMEOUT_EN
        begin
            rsp_t e;
            exp_q.push_back(rsp_t'{32'hDEADBEEF, 1'b1});
            send(1'b0, 26'h0000020, 32'h0, ok);
            wait_drop(40, k, stable);
            n_tests++;
            if (!ok || k !== 16 || stable !== 1'b1)
                begin n_fail++; $display("FAIL timeout_edge: ok=%b cyc dropped after %0d edges stable=%b, want 1 16 1", ok, k, stable); end
            e = exp_q.pop_front();
            n_tests++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== e.dat || bus.rsp_err !== e.err || bus.stb_o !== 1'b0)
                begin n_fail++; $display("FAIL timeout_rsp: valid=%b dat=%h err=%b stb=%b, want 1 %h %b 0",
                    bus.rsp_valid, bus.rsp_dat, bus.rsp_err, bus.stb_o, e.dat, e.err); end
            @(posedge clk);
            #1;
            n_tests++;
            if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
                begin n_fail++; $display("FAIL timeout_handshake: rsp_valid=%b ready=%b, want 0 1", bus.rsp_valid, bus.req_ready); end
            @(negedge clk);
        end
`else
        send(1'b0, 26'h0000020, 32'h0, ok);
        wait_drop(100, k, stable);
        n_tests++;
        if (!ok || k !== 100 || bus.cyc_o !== 1'b1 || stable !== 1'b1)
            begin n_fail++; $display("FAIL no_timeout_hold: ok=%b edges=%0d cyc=%b stable=%b, want 1 100 1 1", ok, k, bus.cyc_o, stable); end
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0)
            begin n_fail++; $display("FAIL no_timeout_rsp: rsp_valid=%b err=%b, want 0 0", bus.rsp_valid, bus.rsp_err); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
`endif
        slave_mute = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok, stable;
        int k;
        rsp_t e;
        ack_wait    = 0;
        slave_rdata = 32'h5A5A1234;
        bus.rsp_ready = 1'b0;
        exp_q.push_back(rsp_t'{32'h5A5A1234, 1'b0});
        send(1'b0, 26'h0000044, 32'h0, ok);
        wait_drop(20, k, stable);
        n_tests++;
        if (!ok || k !== 1)
            begin n_fail++; $display("FAIL bp_zero_wait: ok=%b edges=%0d, want 1 1", ok, k); end
        e = exp_q.pop_front();
        n_tests++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== e.dat || bus.rsp_err !== e.err)
            begin n_fail++; $display("FAIL bp_rsp: valid=%b dat=%h err=%b, want 1 %h %b", bus.rsp_valid, bus.rsp_dat, bus.rsp_err, e.dat, e.err); end
        // Second command waits while the first response is stalled.
        bus.req_we    = 1'b1;
        bus.req_adr   = 26'h3FFFFFF;
        bus.req_dat   = 32'hA5A5A5A5;
        bus.req_valid = 1'b1;
        exp_q.push_back(rsp_t'{32'h0, 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== e.dat || bus.req_ready !== 1'b0 || bus.cyc_o !== 1'b0)
                begin n_fail++; $display("FAIL bp_hold[%0d]: valid=%b dat=%h ready=%b cyc=%b, want 1 %h 0 0",
                    i, bus.rsp_valid, bus.rsp_dat, bus.req_ready, bus.cyc_o, e.dat); end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || bus.cyc_o !== 1'b0 || bus.req_ready !== 1'b1)
            begin n_fail++; $display("FAIL bp_handshake: valid=%b cyc=%b ready=%b, want 0 0 1", bus.rsp_valid, bus.cyc_o, bus.req_ready); end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n_tests++;
        if (bus.cyc_o !== 1'b1 || bus.adr_o !== 26'h3FFFFFF || bus.dat_o !== 32'hA5A5A5A5)
            begin n_fail++; $display("FAIL bp_second_accept: cyc=%b adr=%h dat=%h, want 1 3ffffff a5a5a5a5", bus.cyc_o, bus.adr_o, bus.dat_o); end
        wait_drop(20, k, stable);
        e = exp_q.pop_front();
        n_tests++;
        if (k !== 1 || bus.rsp_valid !== 1'b1 || bus.rsp_dat !== e.dat || bus.rsp_err !== e.err)
            begin n_fail++; $display("FAIL bp_second_rsp: edges=%0d valid=%b dat=%h err=%b, want 1 1 %h %b",
                k, bus.rsp_valid, bus.rsp_dat, bus.rsp_err, e.dat, e.err); end
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_cycle();
        bit ok;
        slave_mute = 1'b1;
        send(1'b1, 26'h0000ABC, 32'h11112222, ok);
        n_tests++;
        if (!ok || bus.stb_o !== 1'b1)
            begin n_fail++; $display("FAIL rstmid_start: ok=%b stb=%b, want 1 1", ok, bus.stb_o); end
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.cyc_o !== 1'b0 || bus.stb_o !== 1'b0 || bus.rsp_valid !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_async: cyc=%b stb=%b valid=%b, want 0 0 0", bus.cyc_o, bus.stb_o, bus.rsp_valid); end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.cyc_o !== 1'b0 || bus.rsp_valid !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_hold: cyc=%b valid=%b, want 0 0", bus.cyc_o, bus.rsp_valid); end
        @(negedge clk);
        rst = 1'b1;
        slave_mute = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.cyc_o !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_release: ready=%b valid=%b cyc=%b, want 1 0 0", bus.req_ready, bus.rsp_valid, bus.cyc_o); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [25:0] adr_t[4];
        logic [31:0] dat_t[4];
        int   acc_at[4];
        int   n_acc = 0;
        int   n_rsp = 0;
        logic prev_cyc = 1'b0;
        logic prev_rv  = 1'b0;
        rsp_t e;
        for (int i = 0; i < 4; i++) begin
            adr_t[i] = 26'h0000100 + 26'(4 * i);
            dat_t[i] = 32'hB0B00000 + 32'(i);
            acc_at[i] = 0;
            exp_q.push_back(rsp_t'{32'h0, 1'b0});
        end
        ack_wait      = 0;
        bus.rsp_ready = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_adr   = adr_t[0];
        bus.req_dat   = dat_t[0];
        bus.req_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.cyc_o && !prev_cyc) begin
                if (n_acc < 4) begin
                    n_tests++;
                    if (bus.adr_o !== adr_t[n_acc] || bus.dat_o !== dat_t[n_acc])
                        begin n_fail++; $display("FAIL b2b_cmd[%0d]: adr=%h dat=%h, want %h %h", n_acc, bus.adr_o, bus.dat_o, adr_t[n_acc], dat_t[n_acc]); end
                    acc_at[n_acc] = c;
                end
                n_acc++;
                if (n_acc < 4) begin
                    bus.req_adr = adr_t[n_acc];
                    bus.req_dat = dat_t[n_acc];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            if (bus.rsp_valid && !prev_rv) begin
                if (n_rsp < 4 && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_tests++;
                    if (bus.rsp_dat !== e.dat || bus.rsp_err !== e.err || bus.adr_o !== adr_t[n_rsp])
                        begin n_fail++; $display("FAIL b2b_rsp[%0d]: dat=%h err=%b adr=%h, want %h %b %h",
                            n_rsp, bus.rsp_dat, bus.rsp_err, bus.adr_o, e.dat, e.err, adr_t[n_rsp]); end
                end
                n_rsp++;
            end
            prev_cyc = bus.cyc_o;
            prev_rv  = bus.rsp_valid;
        end
        bus.req_valid = 1'b0;
        n_tests++;
        if (n_acc !== 4 || n_rsp !== 4)
            begin n_fail++; $display("FAIL b2b_count: cycles=%0d responses=%0d, want 4 4", n_acc, n_rsp); end
        for (int i = 1; i < 4; i++) begin
            n_tests++;
            if (acc_at[i] - acc_at[i-1] !== 3)
                begin n_fail++; $display("FAIL b2b_spacing[%0d]: %0d clocks, want 3", i, acc_at[i] - acc_at[i-1]); end
        end
        @(negedge clk);
    endtask

    // Watchdog: the run must always end.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_adr   = '0;
        bus.req_dat   = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_backpressure();
        test_reset_mid_cycle();
        test_back_to_back();
        n_tests++;
        if (exp_q.size() !== 0)
            begin n_fail++; $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wishb_master.md
# wishb_master

Wishbone classic-cycle initiator that drives the memory/SSP Wishbone slave from a simple valid/ready request port. It accepts one command at a time (read or write, 26-bit address, 32-bit data) and runs a single Wishbone cycle. It waits for `ack_i`, then returns read data, or an error on timeout, through a response port with backpressure. It sits between the command source (CPU core or test sequencer) and the slave's `adr_i/dat_i/we_i/stb_i/cyc_i` pins.

## Interface
- `TIMEOUT`, default 16: maximum bus cycles to wait for `ack_i` (legal range 2..255).
- `ERR_DATA`, default 32'hDEADBEEF: value returned on `rsp_dat` for a timed-out read.

Ports:
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  command can be accepted.
- `req_we`  in  1  1 = write, 0 = read.
- `req_adr`  in  26  target address.
- `req_dat`  in  32  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_dat`  out  32  read data (0 for writes).
- `rsp_err`  out  1  cycle ended by timeout.
- `adr_o`  out  26  Wishbone address.
- `dat_o`  out  32  Wishbone write data.
- `dat_i`  in  32  Wishbone read data.
- `we_o`  out  1  Wishbone write enable.
- `stb_o`  out  1  Wishbone strobe.
- `cyc_o`  out  1  Wishbone cycle.
- `ack_i`  in  1  Wishbone acknowledge.

## Operation
- FSM states: IDLE, BUS, RESP. Reset enters IDLE.
- IDLE: `req_ready`=1. On `req_valid & req_ready`, register `req_adr/req_dat/req_we` into `adr_o/dat_o/we_o`, set `cyc_o`=`stb_o`=1, clear timeout counter, go to BUS.
- BUS: `req_ready`=0. `cyc_o/stb_o/adr_o/dat_o/we_o` stay stable.
  - On an edge with `ack_i`=1: drop `cyc_o/stb_o` and `we_o`. Load `rsp_dat` with `dat_i` for reads or 0 for writes. Set `rsp_err`=0 and `rsp_valid`=1, then go to RESP.
  - Otherwise increment the counter.
  - When the counter reaches `TIMEOUT-1` with no ack: drop `cyc_o/stb_o`. Load `rsp_dat` with `ERR_DATA` for reads or 0 for writes. Set `rsp_err`=1 and `rsp_valid`=1, then go to RESP.
  - If ack and timeout occur on the same edge, ack wins (`rsp_err`=0).
- RESP: hold `rsp_valid/rsp_dat/rsp_err` until `rsp_ready`=1. On that edge clear `rsp_valid` and go to IDLE. A new request is accepted at the earliest one edge later.
- `req_*` inputs are ignored outside IDLE. `ack_i` is ignored outside BUS. A stray ack has no effect.
- Counter width is 8 bits and saturates; it never wraps during a cycle.
- Reset asserted in any state, including mid-BUS, forces IDLE immediately (asynchronously). The cycle is abandoned and no response is produced.

## Timing
- Reset values: `cyc_o`=0, `stb_o`=0, `we_o`=0, `adr_o`=0, `dat_o`=0, `rsp_valid`=0, `rsp_dat`=0, `rsp_err`=0. `req_ready`=1, decoded from IDLE.
- Accept edge T: `cyc_o/stb_o` high from T.
- Ack sampled at edge T+n (n≥1): `cyc_o/stb_o` low and `rsp_valid` high from T+n. A zero-wait ack, seen at T+1, gives a bus cycle of one clock.
- The slave asserts `ack_i` on its falling edge, so ack follows `stb_o` within half a clock. A minimum read costs 1 bus clock plus the RESP handshake.
- Timeout: no ack means `cyc_o` drops at edge T+`TIMEOUT`.
- Throughput with `rsp_ready` tied high: one command per 3 clocks (IDLE, BUS, RESP).

## Configuration
- `WISHB_MASTER_TIMEOUT_EN` defined: timeout counter and `rsp_err` path built as described above.
- Not defined:
  - No counter.
  - BUS waits for `ack_i` indefinitely.
  - `rsp_err` is tied to 0.
  - `TIMEOUT` and `ERR_DATA` are unused.

## Test plan
- Write: `req_we`=1, `req_adr`=26'h0010004, `req_dat`=32'h12345678, slave acks after 2 clocks. Require `adr_o/dat_o/we_o` stable while `stb_o` is high, `cyc_o` dropped on the ack edge, and response `rsp_dat`=0, `rsp_err`=0.
- Read: `req_adr`=26'h0000010, ack with `dat_i`=32'hCAFEF00D. Require `rsp_dat`=32'hCAFEF00D, `rsp_err`=0, and `we_o`=0 throughout.
- Timeout (macro on, `TIMEOUT`=16): read, `ack_i` held low. Require `cyc_o` low exactly 16 edges after accept, `rsp_err`=1, `rsp_dat`=32'hDEADBEEF. With the macro off, require `cyc_o` to stay high for 100 clocks.
- Backpressure: hold `rsp_ready`=0 for 5 clocks after a read. Require `rsp_valid/rsp_dat` stable, `req_ready`=0, and a second `req_valid` not accepted until the cycle after the handshake.
- Reset mid-cycle: drop `rst_i` while `stb_o`=1. Require `cyc_o/stb_o`=0 before the next clock edge, no `rsp_valid`, and `req_ready`=1 after release.
- Back-to-back: 4 writes with `req_valid` and `rsp_ready` held high and immediate ack. Require exactly 4 cycles and 4 responses in order, one per 3 clocks.
